// File: rtl/camera_pixel_assembler_pkg.sv
// Shared types and constants for the OV7670 pixel assembler.
// Holds the default frame geometry, the FSM state type and the test-pattern colour lookup.
package camera_pixel_assembler_pkg;

  localparam int unsigned CAMERA_WIDTH        = 320;
  localparam int unsigned CAMERA_HEIGHT       = 240;
  localparam int unsigned CAMERA_FRAME_PIXELS = CAMERA_WIDTH * CAMERA_HEIGHT;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PIXEL_W = 16;
  localparam int unsigned X_W     = 9;
  localparam int unsigned Y_W     = 8;
  localparam int unsigned COUNT_W = 17;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_HIGH,
    WAIT_LOW
  } camera_asm_state_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] data;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } camera_pixel_t;

  // Full-scale RGB565 colour for one of the eight vertical bars.
  function automatic logic [PIXEL_W-1:0] camera_bar_colour(input logic [2:0] bar);
    logic [PIXEL_W-1:0] colour;
    colour = 16'h0000;
    case (bar)
      3'd0: colour = 16'hFFFF;
      3'd1: colour = 16'hFFE0;
      3'd2: colour = 16'h07FF;
      3'd3: colour = 16'h07E0;
      3'd4: colour = 16'hF81F;
      3'd5: colour = 16'hF800;
      3'd6: colour = 16'h001F;
      default: colour = 16'h0000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/camera_pixel_assembler_if.sv
// Camera byte bus in, assembled pixel stream out.
// master: camera/consumer side; slave: the assembler.
interface camera_pixel_assembler_if;
  import camera_pixel_assembler_pkg::*;

  logic               camera_vsync_in;
  logic               camera_href_in;
  logic [BYTE_W-1:0]  camera_data_in;
  logic [PIXEL_W-1:0] pixel_data;
  logic               pixel_valid;
  logic               frame_done;
  logic               frame_error;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;

  modport master (
    output camera_vsync_in, camera_href_in, camera_data_in,
    input  pixel_data, pixel_valid, frame_done, frame_error, pixel_x, pixel_y
  );

  modport slave (
    input  camera_vsync_in, camera_href_in, camera_data_in,
    output pixel_data, pixel_valid, frame_done, frame_error, pixel_x, pixel_y
  );

endinterface

// File: rtl/camera_sync_edge.sv
// Two-stage register on a camera control line with rise/fall pulses
// derived from the two stages (pulses valid alongside q_o).
module camera_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic q_q;
  logic q2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q  <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q_q  <= d_i;
      q2_q <= q_q;
    end
  end

  assign q_o      = q_q;
  assign rise_c_o = q_q & ~q2_q;
  assign fall_c_o = ~q_q & q2_q;

endmodule

// File: rtl/camera_pixel_assembler.sv
// Pairs OV7670 bytes into RGB565 pixels with frame/line accounting and frame_done/frame_error.
// Define CAMERA_TEST_PATTERN_EN to replace pixel data with eight vertical colour bars.
module camera_pixel_assembler
  import camera_pixel_assembler_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = CAMERA_WIDTH,
  parameter int unsigned FRAME_HEIGHT = CAMERA_HEIGHT
) (
  input  logic                     pixel_clock_in,
  input  logic                     reset_in,
  camera_pixel_assembler_if.slave  bus_if
);

  localparam logic [X_W-1:0]     X_LIMIT      = X_W'(FRAME_WIDTH);
  localparam logic [Y_W-1:0]     Y_LIMIT      = Y_W'(FRAME_HEIGHT);
  localparam logic [COUNT_W-1:0] COUNT_TARGET = COUNT_W'(FRAME_WIDTH * FRAME_HEIGHT);

  camera_asm_state_t  state_q, state_d;
  logic [BYTE_W-1:0]  data_q;
  logic [BYTE_W-1:0]  high_q, high_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               line_err_q, line_err_d;
  logic               overflow_q, overflow_d;
  camera_pixel_t      pix_q, pix_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               href_q;
  logic               href_rise_unused;
  logic               href_fall;
  logic               vsync_level_unused;
  logic               vsync_rise;
  logic               vsync_fall;
  logic               active;
  logic               emit_req;
  logic [PIXEL_W-1:0] pixel_word;

  camera_sync_edge u_vsync (
    .clk_i    (pixel_clock_in),
    .rst_i    (reset_in),
    .d_i      (bus_if.camera_vsync_in),
    .q_o      (vsync_level_unused),
    .rise_c_o (vsync_rise),
    .fall_c_o (vsync_fall)
  );

  camera_sync_edge u_href (
    .clk_i    (pixel_clock_in),
    .rst_i    (reset_in),
    .d_i      (bus_if.camera_href_in),
    .q_o      (href_q),
    .rise_c_o (href_rise_unused),
    .fall_c_o (href_fall)
  );

`ifdef CAMERA_TEST_PATTERN_EN
  localparam int unsigned XS_W = X_W + 3;
  logic [XS_W-1:0] x_scaled;
  assign x_scaled   = {x_q, 3'b000};
  assign pixel_word = camera_bar_colour(3'(x_scaled / XS_W'(FRAME_WIDTH)));
`else
  assign pixel_word = {high_q, data_q};
`endif

  assign active = (state_q != WAIT_FRAME);

  // Byte pairing, line/frame accounting and strobe generation.
  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    x_d        = x_q;
    y_d        = y_q;
    count_d    = count_q;
    line_err_d = line_err_q;
    overflow_d = overflow_q;
    pix_d      = pix_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    emit_req   = 1'b0;

    unique case (state_q)
      WAIT_FRAME: begin
        if (vsync_fall) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (href_q) begin
          high_d  = data_q;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        state_d = WAIT_HIGH;
        if (href_q) emit_req = 1'b1;
        else        line_err_d = 1'b1;
      end
      default: state_d = WAIT_FRAME;
    endcase

    // Pixels beyond the frame geometry are swallowed; counters hold at the limit.
    if (emit_req) begin
      if ((x_q >= X_LIMIT) || (y_q >= Y_LIMIT)) begin
        overflow_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        pix_d   = '{data: pixel_word, x: x_q, y: y_q};
        x_d     = x_q + X_W'(1);
        count_d = count_q + COUNT_W'(1);
      end
    end

    if (active && href_fall) begin
      x_d = '0;
      if ((x_q != '0) && (y_q < Y_LIMIT)) y_d = y_q + Y_W'(1);
    end

    // A pixel emitted on the closing edge still belongs to the ending frame.
    if (active && vsync_rise) begin
      done_d     = 1'b1;
      error_d    = (count_d != COUNT_TARGET) || line_err_d || overflow_d;
      state_d    = WAIT_FRAME;
      x_d        = '0;
      y_d        = '0;
      count_d    = '0;
      line_err_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) begin
      state_q    <= WAIT_FRAME;
      data_q     <= '0;
      high_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      count_q    <= '0;
      line_err_q <= 1'b0;
      overflow_q <= 1'b0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= bus_if.camera_data_in;
      high_q     <= high_d;
      x_q        <= x_d;
      y_q        <= y_d;
      count_q    <= count_d;
      line_err_q <= line_err_d;
      overflow_q <= overflow_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus_if.pixel_data  = pix_q.data;
  assign bus_if.pixel_x     = pix_q.x;
  assign bus_if.pixel_y     = pix_q.y;
  assign bus_if.pixel_valid = valid_q;
  assign bus_if.frame_done  = done_q;
  assign bus_if.frame_error = error_q;

endmodule
